// File: rtl/div_pkg.sv
// Shared types and sizing for the HI/LO divide controller and its restoring step.
package div_pkg;
   localparam int DIV_WIDTH = 32;
   localparam int DIV_ITERS = 32;
   localparam int CNT_W     = 6;

   typedef enum logic [2:0] {
      IDLE,
      PREP,
      ITER,
      FIX,
      DONE
   } div_state_e;
endpackage

// File: rtl/div_step.sv
// One combinational restoring shift-subtract step: shift in the next dividend bit, trial-subtract the divisor.
module div_step
   import div_pkg::*;
(
   input  logic [DIV_WIDTH-1:0] rem_in,
   input  logic [DIV_WIDTH-1:0] dsr,
   input  logic                 bit_in,
   output logic [DIV_WIDTH-1:0] rem_out,
   output logic                 q_bit
);

   logic [DIV_WIDTH:0] shifted;
   logic [DIV_WIDTH:0] diff;

   // rem_in < dsr keeps shifted below 2*dsr, so the top bit of diff is a clean borrow flag.
   always_comb begin
      shifted = {rem_in, bit_in};
      diff    = shifted - {1'b0, dsr};
      q_bit   = ~diff[DIV_WIDTH];
      rem_out = q_bit ? diff[DIV_WIDTH-1:0] : shifted[DIV_WIDTH-1:0];
   end

endmodule

// File: rtl/hilo_div_ctrl.sv
// Multi-cycle DIV/DIVU controller writing quotient to LO and remainder to HI.
// Optional HILO_DIV_EARLY_EXIT_EN skips iteration when the quotient is trivially zero.
module hilo_div_ctrl
   import div_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        is_signed,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        cancel,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIV_ITERS - 1);

   div_state_e           state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [DIV_WIDTH-1:0] hi_q, hi_d;
   logic [DIV_WIDTH-1:0] lo_q, lo_d;

   logic [DIV_WIDTH-1:0] a_q, a_d;
   logic [DIV_WIDTH-1:0] b_q, b_d;
   logic                 sgn_q, sgn_d;
   logic [DIV_WIDTH-1:0] dvd_q, dvd_d;
   logic [DIV_WIDTH-1:0] dsr_q, dsr_d;
   logic [DIV_WIDTH-1:0] rem_q, rem_d;
   logic                 qneg_q, qneg_d;
   logic                 rneg_q, rneg_d;
   logic                 dz_q, dz_d;

   logic [DIV_WIDTH-1:0] abs_a, abs_b;
   logic [DIV_WIDTH-1:0] step_rem;
   logic                 step_q;
   logic                 early;

   function automatic logic sign_of(input logic [DIV_WIDTH-1:0] v, input logic en);
      sign_of = en & v[DIV_WIDTH-1];
   endfunction

   // Two's-complement negate; 0x80000000 maps to itself, which gives the wrapped overflow result.
   function automatic logic [DIV_WIDTH-1:0] neg_if(input logic [DIV_WIDTH-1:0] v, input logic en);
      logic signed [DIV_WIDTH-1:0] sv;
      sv     = v;
      neg_if = en ? -sv : sv;
   endfunction

   div_step u_step (
      .rem_in  (rem_q),
      .dsr     (dsr_q),
      .bit_in  (dvd_q[DIV_WIDTH-1]),
      .rem_out (step_rem),
      .q_bit   (step_q)
   );

   always_comb begin
      abs_a = neg_if(a_q, sign_of(a_q, sgn_q));
      abs_b = neg_if(b_q, sign_of(b_q, sgn_q));
`ifdef HILO_DIV_EARLY_EXIT_EN
      early = (b_q == '0) || (abs_a < abs_b);
`else
      early = 1'b0;
`endif
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      a_d     = a_q;
      b_d     = b_q;
      sgn_d   = sgn_q;
      dvd_d   = dvd_q;
      dsr_d   = dsr_q;
      rem_d   = rem_q;
      qneg_d  = qneg_q;
      rneg_d  = rneg_q;
      dz_d    = dz_q;

      case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (start) begin
               a_d     = a;
               b_d     = b;
               sgn_d   = is_signed;
               state_d = PREP;
            end
         end
         PREP: begin
            dvd_d   = abs_a;
            dsr_d   = abs_b;
            rem_d   = '0;
            qneg_d  = sign_of(a_q, sgn_q) ^ sign_of(b_q, sgn_q);
            rneg_d  = sign_of(a_q, sgn_q);
            dz_d    = (b_q == '0);
            cnt_d   = '0;
            state_d = ITER;
            if (early) begin
               dvd_d   = '0;
               rem_d   = (b_q == '0) ? '0 : abs_a;
               state_d = FIX;
            end
         end
         // The dividend register doubles as the quotient: bits leave at the top, quotient bits enter at the bottom.
         ITER: begin
            dvd_d = {dvd_q[DIV_WIDTH-2:0], step_q};
            rem_d = step_rem;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_CNT) begin
               state_d = FIX;
            end
         end
         FIX: begin
            lo_d    = dz_q ? '0 : neg_if(dvd_q, qneg_q);
            hi_d    = dz_q ? '0 : neg_if(rem_q, rneg_q);
            cnt_d   = '0;
            state_d = DONE;
         end
         default: state_d = IDLE;
      endcase

      if (cancel) begin
         state_d = IDLE;
         cnt_d   = '0;
         hi_d    = hi_q;
         lo_d    = lo_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   always_ff @(posedge clk) begin
      a_q    <= a_d;
      b_q    <= b_d;
      sgn_q  <= sgn_d;
      dvd_q  <= dvd_d;
      dsr_q  <= dsr_d;
      rem_q  <= rem_d;
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
      dz_q   <= dz_d;
   end

   assign busy = (state_q == PREP) || (state_q == ITER) || (state_q == FIX);
   assign done = (state_q == DONE);
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_hilo_div_ctrl.sv
// Directed bench for hilo_div_ctrl: transaction-level timing/result model checked every cycle, plus literal checks.
module tb_hilo_div_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        start = 1'b0;
   logic        is_signed = 1'b0;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        cancel = 1'b0;
   logic        busy, done;
   logic [31:0] hi, lo;

   int cyc = 0;
   int tests = 0;
   int fails = 0;

   hilo_div_ctrl dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .is_signed (is_signed),
      .a         (a),
      .b         (b),
      .cancel    (cancel),
      .busy      (busy),
      .done      (done),
      .hi        (hi),
      .lo        (lo)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout, required $finish");
      $fatal(1, "watchdog");
   end

   // Reference arithmetic straight from the DIV/DIVU rules.
   function automatic void ref_div(input logic s, input logic [31:0] av, input logic [31:0] bv,
                                   output logic [31:0] q, output logic [31:0] r);
      logic signed [31:0] sa, sb;
      sa = av;
      sb = bv;
      if (bv == 32'd0) begin
         q = '0; r = '0;
      end else if (!s) begin
         q = av / bv; r = av % bv;
      end else if (av == 32'h8000_0000 && bv == 32'hFFFF_FFFF) begin
         q = 32'h8000_0000; r = '0;
      end else begin
         q = sa / sb; r = sa % sb;
      end
   endfunction

   function automatic bit ref_early(input logic s, input logic [31:0] av, input logic [31:0] bv);
      logic [31:0] ma, mb;
      ma = (s && av[31]) ? -av : av;
      mb = (s && bv[31]) ? -bv : bv;
      return (bv == 32'd0) || (ma < mb);
   endfunction

   // Transaction model: an accepted op completes a fixed number of edges later.
   logic        m_busy = 1'b0;
   logic        m_done = 1'b0;
   logic [31:0] m_hi = '0;
   logic [31:0] m_lo = '0;
   logic [31:0] r_hi = '0;
   logic [31:0] r_lo = '0;
   int          m_left = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy = 1'b0; m_done = 1'b0; m_hi = '0; m_lo = '0; m_left = 0;
      end else begin
         m_done = 1'b0;
         if (cancel) begin
            m_busy = 1'b0;
         end else if (m_busy) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
               m_busy = 1'b0; m_done = 1'b1; m_hi = r_hi; m_lo = r_lo;
            end
         end else if (start) begin
            ref_div(is_signed, a, b, r_lo, r_hi);
            m_busy = 1'b1;
            m_left = 34;
`ifdef HILO_DIV_EARLY_EXIT_EN
            if (ref_early(is_signed, a, b)) m_left = 2;
`endif
         end
      end
   end

   always @(negedge clk) begin
      tests++;
      if (busy !== m_busy || done !== m_done || hi !== m_hi || lo !== m_lo) begin
         fails++;
         $display("FAIL cycle_model cyc=%0d: busy/done/hi/lo got %b/%b/%h/%h required %b/%b/%h/%h",
                  cyc, busy, done, hi, lo, m_busy, m_done, m_hi, m_lo);
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h, required 0x%08h", nm, act, exp);
      end
   endtask

   task automatic go_cycle(input int c);
      while (cyc < c) begin
         @(posedge clk); #1;
      end
   endtask

   function automatic int exp_lat(input bit elig);
`ifdef HILO_DIV_EARLY_EXIT_EN
      return elig ? 3 : 35;
`else
      return (elig === 1'bx) ? 0 : 35;
`endif
   endfunction

   task automatic wait_done(input int c0, input int lat, input string nm);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 80 && !seen; i++) begin
         @(negedge clk);
         seen = (done === 1'b1);
      end
      if (!seen) begin
         tests++; fails++;
         $display("FAIL %s_timeout: got no done pulse, required done at cycle %0d", nm, lat);
      end else begin
         chk({nm, "_latency"}, 32'(cyc - c0), 32'(lat));
      end
   endtask

   task automatic run_op(input logic s, input logic [31:0] av, input logic [31:0] bv,
                         input logic [31:0] elo, input logic [31:0] ehi, input bit elig,
                         input string nm);
      int c0;
      c0 = cyc;
      start = 1'b1; is_signed = s; a = av; b = bv;
      @(posedge clk); #1;
      start = 1'b0; a = $urandom; b = $urandom; is_signed = ~s;
      wait_done(c0, exp_lat(elig), nm);
      chk({nm, "_lo"}, lo, elo);
      chk({nm, "_hi"}, hi, ehi);
      @(posedge clk); #1;
   endtask

   initial begin
      int c0, c1, nd;

      #2 rst_n = 1'b0;
      #2;
      chk("reset_busy", {31'd0, busy}, 32'd0);
      chk("reset_done", {31'd0, done}, 32'd0);
      chk("reset_hi", hi, 32'd0);
      chk("reset_lo", lo, 32'd0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // First start issued in the same cycle reset releases.
      run_op(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, "divu_100_7");
      run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, "div_m7_2");
      run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, "div_ovf");
      run_op(1'b0, 32'd5, 32'd0, 32'd0, 32'd0, 1'b1, "divu_by0");
      run_op(1'b1, 32'd5, 32'd0, 32'd0, 32'd0, 1'b1, "div_by0");
      run_op(1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0, "div_7_m2");
      run_op(1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, "divu_max_1");
      run_op(1'b0, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 32'd1, 1'b0, "divu_big_2");
      run_op(1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 32'hFFFF_FFFE, 1'b0, "div_m100_m7");

      // Cancel mid-operation, then a fresh op two cycles later.
      c0 = cyc;
      start = 1'b1; is_signed = 1'b0; a = 32'd100; b = 32'd7;
      go_cycle(c0 + 1); start = 1'b0;
      go_cycle(c0 + 10); cancel = 1'b1;
      go_cycle(c0 + 11); cancel = 1'b0;
      chk("cancel_busy", {31'd0, busy}, 32'd0);
      chk("cancel_hi_kept", hi, 32'hFFFF_FFFE);
      chk("cancel_lo_kept", lo, 32'd14);
      go_cycle(c0 + 12);
      start = 1'b1; is_signed = 1'b0; a = 32'd9; b = 32'd3;
      go_cycle(c0 + 13); start = 1'b0;
      wait_done(c0, 47, "after_cancel");
      chk("after_cancel_lo", lo, 32'd3);
      chk("after_cancel_hi", hi, 32'd0);
      @(posedge clk); #1;

      // Cancel and start together from idle: cancel wins.
      c0 = cyc;
      start = 1'b1; cancel = 1'b1; a = 32'd8; b = 32'd2;
      go_cycle(c0 + 1); start = 1'b0; cancel = 1'b0;
      chk("cancel_wins_busy", {31'd0, busy}, 32'd0);
      go_cycle(c0 + 2);

      // Starts while busy are ignored; a start in the DONE cycle is accepted.
      c0 = cyc;
      start = 1'b1; is_signed = 1'b0; a = 32'd100; b = 32'd7;
      go_cycle(c0 + 1); start = 1'b0;
      go_cycle(c0 + 5); start = 1'b1; a = 32'd1; b = 32'd1;
      go_cycle(c0 + 6); start = 1'b0;
      go_cycle(c0 + 20); start = 1'b1; is_signed = 1'b1; a = 32'd2; b = 32'd1;
      go_cycle(c0 + 21); start = 1'b0;
      wait_done(c0, 35, "ignore_start");
      chk("ignore_start_lo", lo, 32'd14);
      chk("ignore_start_hi", hi, 32'd2);
      c1 = cyc;
      start = 1'b1; is_signed = 1'b0; a = 32'd50; b = 32'd6;
      @(posedge clk); #1; start = 1'b0;
      wait_done(c1, 35, "back_to_back");
      chk("back_to_back_lo", lo, 32'd8);
      chk("back_to_back_hi", hi, 32'd2);
      @(posedge clk); #1;

      // Asynchronous reset mid-operation discards it.
      c0 = cyc;
      start = 1'b1; is_signed = 1'b0; a = 32'd1000; b = 32'd3;
      go_cycle(c0 + 1); start = 1'b0;
      go_cycle(c0 + 15);
      #2 rst_n = 1'b0;
      #1;
      chk("midreset_hi", hi, 32'd0);
      chk("midreset_lo", lo, 32'd0);
      chk("midreset_busy", {31'd0, busy}, 32'd0);
      @(posedge clk); #1 rst_n = 1'b1;
      nd = 0;
      repeat (45) begin
         @(negedge clk);
         if (done === 1'b1) nd++;
      end
      chk("midreset_no_done", 32'(nd), 32'd0);
      @(posedge clk); #1;

      run_op(1'b0, 32'd3, 32'd10, 32'd0, 32'd3, 1'b1, "divu_3_10");
      run_op(1'b1, 32'hFFFF_FFFD, 32'd10, 32'd0, 32'hFFFF_FFFD, 1'b1, "div_m3_10");
      run_op(1'b0, 32'd1000, 32'd3, 32'd333, 32'd1, 1'b0, "divu_1000_3");

      repeat (2) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
